matrix_scan_sequencer: RTL and testbench
========================================

# matrix_scan_sequencer

Free-running scan sequencer for the LED matrix display. It steps a column index `mdc` and a row index `mdl` across the matrix and holds each position for a programmable dwell time. It inserts one blanking cycle between positions and flags the end of every frame. Its `mdc`/`mdl` outputs drive the 1-to-8 demux select decoder directly. `scan_valid` gates the demux enable.

## Interface
Parameters:
- `COLS`, default 5: columns scanned, legal range 1..8; `mdc` counts 0..COLS-1.
- `ROWS`, default 7: rows scanned, legal range 1..8; `mdl` counts 0..ROWS-1.
- `DWELL`, default 4: cycles each position is held valid, must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; sampled only in IDLE and at end of frame.
- `hold`  in  1  freezes the dwell counter while in SCAN.
- `sync_clr`  in  1  synchronous frame restart.
- `mdc`  out  3  current column index, registered.
- `mdl`  out  3  current row index, registered.
- `scan_valid`  out  1  high while the current position is being displayed.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: `busy`=0, `scan_valid`=0, coordinates (0,0).
  - SCAN: `scan_valid`=1, dwell counter active.
  - BLANK: `scan_valid`=0, lasts exactly 1 cycle.
- Scan order: column-major inner loop. `mdc` increments first; when `mdc`=COLS-1 it wraps to 0 and `mdl` increments. The last position is (COLS-1, ROWS-1).
- IDLE → SCAN when `en`=1. SCAN starts at (0,0) with dwell count 0.
- SCAN → BLANK when dwell count reaches DWELL-1 and `hold`=0. `mdc`/`mdl` advance on entry to BLANK so the downstream decode settles while the display is blanked.
- BLANK → SCAN always, except after the last position.
- After the last position, coordinates wrap to (0,0) on entry to BLANK and `frame_done`=1 during that BLANK cycle. From that BLANK, go to SCAN if `en`=1, otherwise go to IDLE.
- Deasserting `en` mid-frame does not abort the frame; the frame completes.
- `hold`=1 in SCAN: dwell counter and coordinates freeze and `scan_valid` stays 1. `hold` has no effect in IDLE or BLANK.
- `sync_clr`=1 has priority over everything except reset:
  - Next state is BLANK with coordinates (0,0) and the dwell counter cleared.
  - `frame_done` is not pulsed.
  - From IDLE, `sync_clr` does the same only if `en`=1; otherwise it is ignored.
- Widths: dwell counter is $clog2(DWELL) bits, minimum 1. `mdc`/`mdl` are 3 bits; their unused upper codes are never produced.

## Timing
- Reset values: `mdc`=0, `mdl`=0, `scan_valid`=0, `frame_done`=0, `busy`=0, state IDLE. Reset takes effect immediately and asynchronously at any point, including mid-frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from `en` rising in IDLE to `scan_valid`=1 is 1 cycle.
- Each position shows DWELL cycles of `scan_valid`=1, then 1 blank cycle. Position period is DWELL+1 cycles (default 5).
- Frame period is COLS·ROWS·(DWELL+1) cycles (default 175) with `en` held and `hold`=0. Consecutive `frame_done` pulses are exactly that far apart.
- `hold` extends the current position by one cycle per held cycle; the frame period grows accordingly.
- Degenerate cases:
  - COLS=1: `mdc` stays at 0.
  - ROWS=1: `mdl` stays at 0.
  - COLS=ROWS=1: every BLANK is an end-of-frame BLANK.

## Test plan
- Reset, then `en`=1 held, defaults: `scan_valid` rises 1 cycle after `en`. Positions follow (0,0),(1,0)…(4,0),(0,1)…(4,6). Each position has 4 valid cycles and 1 blank cycle. `frame_done` pulses every 175 cycles, coordinates (0,0) at the pulse.
- Drop `en` at cycle 60 of a frame: the frame finishes. After the final BLANK, `busy`=0 and the outputs are (0,0) with `scan_valid`=0.
- `hold`=1 for 3 cycles while at (2,3): that position is valid for 7 cycles total. The following `frame_done` arrives 3 cycles later than nominal.
- `sync_clr` pulse while at (3,5): next cycle is BLANK at (0,0) with `frame_done`=0. Then SCAN at (0,0), and the next `frame_done` comes 175 cycles after the restart.
- Assert `rst_n`=0 asynchronously while at (4,2), mid-dwell: all outputs go to 0 immediately. After release with `en`=1, the scan restarts at (0,0).
- COLS=1, ROWS=1, DWELL=1: the output alternates valid/blank every cycle at (0,0), with `frame_done` on every blank cycle.

Source files
------------

// File: rtl/matrix_scan_sequencer.sv
// rtl/matrix_scan_sequencer.sv - column/row scan sequencer with dwell, blanking and frame pulse
module matrix_scan_sequencer #(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic       sync_clr,
  output logic [2:0] mdc,
  output logic [2:0] mdl,
  output logic       scan_valid,
  output logic       frame_done,
  output logic       busy
);

  localparam int             CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
  localparam logic [2:0]     COL_LAST   = 3'(COLS - 1);
  localparam logic [2:0]     ROW_LAST   = 3'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [2:0]    mdc_q, mdc_d;
  logic [2:0]    mdl_q, mdl_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          last_pos;

  // Next-state, dwell and coordinate stepping; outputs are decoded from the next state so they leave flops.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    mdc_d        = mdc_q;
    mdl_d        = mdl_q;
    frame_done_d = 1'b0;
    last_pos     = (mdc_q == COL_LAST) && (mdl_q == ROW_LAST);

    if (sync_clr && ((state_q != IDLE) || en)) begin
      // Restart the frame through a blank cycle so the decoder settles at (0,0).
      state_d = BLANK;
      dwell_d = '0;
      mdc_d   = 3'd0;
      mdl_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = SCAN;
            dwell_d = '0;
            mdc_d   = 3'd0;
            mdl_d   = 3'd0;
          end
        end
        SCAN: begin
          if (!hold) begin
            if (dwell_q == DWELL_LAST) begin
              // Advance coordinates on entry to BLANK; the last position wraps and flags end of frame.
              state_d = BLANK;
              dwell_d = '0;
              if (mdc_q == COL_LAST) begin
                mdc_d = 3'd0;
                mdl_d = (mdl_q == ROW_LAST) ? 3'd0 : mdl_q + 3'd1;
              end else begin
                mdc_d = mdc_q + 3'd1;
              end
              frame_done_d = last_pos;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        BLANK: begin
          // frame_done_q marks the end-of-frame blank, the only place en can stop the scan.
          dwell_d = '0;
          state_d = (frame_done_q && !en) ? IDLE : SCAN;
        end
        default: begin
          state_d = IDLE;
          dwell_d = '0;
          mdc_d   = 3'd0;
          mdl_d   = 3'd0;
        end
      endcase
    end

    scan_valid_d = (state_d == SCAN);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dwell_q      <= '0;
      mdc_q        <= 3'd0;
      mdl_q        <= 3'd0;
      scan_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      mdc_q        <= mdc_d;
      mdl_q        <= mdl_d;
      scan_valid_q <= scan_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mdc        = mdc_q;
  assign mdl        = mdl_q;
  assign scan_valid = scan_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// tb/tb_matrix_scan_sequencer.sv - self-checking bench for matrix_scan_sequencer
module tb_matrix_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hold;
  logic       sync_clr;
  logic [2:0] a_mdc, a_mdl, b_mdc, b_mdl;
  logic       a_sv, a_fd, a_busy, b_sv, b_fd, b_busy;

  int checks = 0;
  int errors = 0;

  // Default geometry 5x7, dwell 4.
  matrix_scan_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .sync_clr(sync_clr),
    .mdc(a_mdc), .mdl(a_mdl), .scan_valid(a_sv), .frame_done(a_fd), .busy(a_busy)
  );

  // Degenerate geometry 1x1, dwell 1.
  matrix_scan_sequencer #(.COLS(1), .ROWS(1), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .sync_clr(sync_clr),
    .mdc(b_mdc), .mdl(b_mdl), .scan_valid(b_sv), .frame_done(b_fd), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Reference model: linear position index and count of valid cycles shown.
  typedef struct {
    bit run;
    bit scan;
    bit eof;
    int pos;
    int el;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.run = 0; m.scan = 0; m.eof = 0; m.pos = 0; m.el = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int nc, int nr, int dw, bit e, bit h, bit s);
    model_t n = m;
    if (s && (m.run || e)) begin
      n.run = 1; n.scan = 0; n.eof = 0; n.pos = 0; n.el = 0;
    end else if (!m.run) begin
      if (e) begin n.run = 1; n.scan = 1; n.pos = 0; n.el = 0; n.eof = 0; end
    end else if (m.scan) begin
      if (!h) begin
        n.el = m.el + 1;
        if (n.el == dw) begin
          n.scan = 0;
          n.pos  = (m.pos + 1) % (nc * nr);
          n.eof  = (n.pos == 0);
          n.el   = 0;
        end
      end
    end else begin
      if (m.eof && !e) n.run = 0;
      else begin n.scan = 1; n.el = 0; end
      n.eof = 0;
    end
    return n;
  endfunction

  function automatic logic [8:0] expect_out(model_t m, int nc);
    return {3'(m.pos % nc), 3'(m.pos / nc), m.run && m.scan, m.run && !m.scan && m.eof, m.run};
  endfunction

  // One clock: models advance with the inputs seen at the edge; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = step(ma, 5, 7, 4, en, hold, sync_clr);
      mb = step(mb, 1, 1, 1, en, hold, sync_clr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; hold = 1'b0; sync_clr = 1'b0;
    ma = model_reset(); mb = model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== 9'd0) begin
      errors++; $display("FAIL reset_a got %0h expected 0", {a_mdc, a_mdl, a_sv, a_fd, a_busy});
    end
    checks++;
    if ({b_mdc, b_mdl, b_sv, b_fd, b_busy} !== 9'd0) begin
      errors++; $display("FAIL reset_b got %0h expected 0", {b_mdc, b_mdl, b_sv, b_fd, b_busy});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_no_en got busy=%0b expected 0", a_busy); end
  endtask

  task automatic test_full_frame();
    int fd1 = 0;
    int fd2 = 0;
    en = 1'b1;
    tick();
    checks++;
    if (a_sv !== 1'b1 || a_mdc !== 3'd0 || a_mdl !== 3'd0) begin
      errors++; $display("FAIL en_latency got sv=%0b (%0d,%0d) expected sv=1 (0,0)", a_sv, a_mdc, a_mdl);
    end
    for (int t = 2; t <= 360; t++) begin
      int k, p, ph;
      logic [8:0] exp_a;
      tick();
      k  = (t - 1) % 175;
      p  = k / 5;
      ph = k % 5;
      if (ph == 4) p = (p + 1) % 35;
      exp_a = {3'(p % 5), 3'(p / 5), ph < 4, (ph == 4) && (p == 0), 1'b1};
      checks++;
      if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== exp_a) begin
        errors++; $display("FAIL frame_seq t=%0d got %0h expected %0h", t, {a_mdc, a_mdl, a_sv, a_fd, a_busy}, exp_a);
      end
      checks++;
      if ({b_mdc, b_mdl, b_sv, b_fd, b_busy} !== expect_out(mb, 1)) begin
        errors++; $display("FAIL frame_seq_b t=%0d got %0h expected %0h", t, {b_mdc, b_mdl, b_sv, b_fd, b_busy}, expect_out(mb, 1));
      end
      if (a_fd) begin
        if (fd1 == 0) fd1 = t;
        else if (fd2 == 0) fd2 = t;
      end
    end
    checks++;
    if (fd1 != 175) begin errors++; $display("FAIL first_frame_done got %0d expected 175", fd1); end
    checks++;
    if (fd2 - fd1 != 175) begin errors++; $display("FAIL frame_period got %0d expected 175", fd2 - fd1); end
  endtask

  task automatic test_en_drop();
    int c = 0;
    bit seen = 0;
    for (int i = 0; i < 200 && !a_fd; i++) tick();
    checks++;
    if (a_fd !== 1'b1) begin errors++; $display("FAIL en_drop_sync got fd=%0b expected 1", a_fd); end
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      c++;
      if (c == 60) en = 1'b0;
      if (a_fd) seen = 1;
    end
    checks++;
    if (c != 175) begin errors++; $display("FAIL en_drop_frame got %0d expected 175", c); end
    tick();
    checks++;
    if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== 9'd0) begin
      errors++; $display("FAIL en_drop_idle got %0h expected 0", {a_mdc, a_mdl, a_sv, a_fd, a_busy});
    end
  endtask

  task automatic test_hold();
    int t = 0;
    int fdt = 0;
    int vcnt = 0;
    int left = 0;
    bit started = 0;
    en = 1'b1;
    for (int i = 0; i < 400 && fdt == 0; i++) begin
      tick();
      t++;
      if (a_fd) fdt = t;
      if (a_sv && a_mdc == 3'd2 && a_mdl == 3'd3) begin
        vcnt++;
        if (!started) begin started = 1; left = 3; end
      end
      hold = (left > 0);
      if (left > 0) left--;
    end
    hold = 1'b0;
    checks++;
    if (vcnt != 7) begin errors++; $display("FAIL hold_valid got %0d expected 7", vcnt); end
    checks++;
    if (fdt != 178) begin errors++; $display("FAIL hold_frame got %0d expected 178", fdt); end
  endtask

  task automatic test_sync_clr();
    int c = 0;
    bit seen = 0;
    for (int i = 0; i < 400 && !(a_sv && a_mdc == 3'd3 && a_mdl == 3'd5); i++) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    checks++;
    if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== 9'b000_000_0_0_1) begin
      errors++; $display("FAIL sync_blank got %0h expected 1", {a_mdc, a_mdl, a_sv, a_fd, a_busy});
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      c++;
      if (c == 1) begin
        checks++;
        if ({a_mdc, a_mdl, a_sv} !== 7'b000_000_1) begin
          errors++; $display("FAIL sync_scan got %0h expected 1", {a_mdc, a_mdl, a_sv});
        end
      end
      if (a_fd) seen = 1;
    end
    checks++;
    if (c != 175) begin errors++; $display("FAIL sync_frame got %0d expected 175", c); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 400 && !(a_sv && a_mdc == 3'd4 && a_mdl == 3'd2); i++) tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== 9'd0) begin
      errors++; $display("FAIL async_reset_a got %0h expected 0", {a_mdc, a_mdl, a_sv, a_fd, a_busy});
    end
    checks++;
    if ({b_mdc, b_mdl, b_sv, b_fd, b_busy} !== 9'd0) begin
      errors++; $display("FAIL async_reset_b got %0h expected 0", {b_mdc, b_mdl, b_sv, b_fd, b_busy});
    end
    ma = model_reset(); mb = model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if ({a_mdc, a_mdl, a_sv, a_busy} !== 8'b000_000_1_1) begin
      errors++; $display("FAIL reset_restart got %0h expected 3", {a_mdc, a_mdl, a_sv, a_busy});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit en_bias;
      en_bias  = ((i / 400) % 3) != 2;
      en       = en_bias ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 9) == 0);
      sync_clr = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if ({a_mdc, a_mdl, a_sv, a_fd, a_busy} !== expect_out(ma, 5)) begin
        errors++; $display("FAIL random_a i=%0d got %0h expected %0h", i, {a_mdc, a_mdl, a_sv, a_fd, a_busy}, expect_out(ma, 5));
      end
      checks++;
      if ({b_mdc, b_mdl, b_sv, b_fd, b_busy} !== expect_out(mb, 1)) begin
        errors++; $display("FAIL random_b i=%0d got %0h expected %0h", i, {b_mdc, b_mdl, b_sv, b_fd, b_busy}, expect_out(mb, 1));
      end
    end
    hold = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic test_degenerate();
    logic prev;
    en = 1'b1;
    tick();
    tick();
    prev = b_sv;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (b_sv !== ~prev || b_fd !== ~b_sv || b_busy !== 1'b1 || b_mdc !== 3'd0 || b_mdl !== 3'd0) begin
        errors++; $display("FAIL degenerate i=%0d got sv=%0b fd=%0b busy=%0b (%0d,%0d) expected sv=%0b fd=%0b busy=1 (0,0)",
                           i, b_sv, b_fd, b_busy, b_mdc, b_mdl, ~prev, prev);
      end
      prev = b_sv;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_en_drop();
    test_hold();
    test_sync_clr();
    test_async_reset();
    test_random();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
